async_mem_wb_master_fe: RTL

//  Synthesizable front end of the async-memory-to-Wishbone bridge. It is the direct consumer of
//  the external asynchronous SRAM-style bus (cs_n/oe_n/we_n/bls_n/a/d) driven by the host CPU
//  or by the testbench async memory master. It synchronises the strobes and turns each write

---
 rtl/async_mem_bridge_pkg.sv | 13 +
 rtl/async_mem_sync.sv | 25 ++
 rtl/async_mem_wb_master_fe.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/async_mem_bridge_pkg.sv
// Shared types for the async-memory to Wishbone bridge.
// Imported by the front end and its helpers.
package async_mem_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD
  } state_t;

  localparam logic [63:0] ERR_DATA = '1;

endpackage

// File: rtl/async_mem_sync.sv
// Multi-flop synchroniser for async strobes.
// Resets to all-ones so strobes look idle.
module async_mem_sync #(
  parameter int width  = 1,
  parameter int stages = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [width-1:0] d,
  output logic [width-1:0] q
);

  logic [stages-1:0][width-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '1;
    end else begin
      sr <= {sr[stages-2:0], d};
    end
  end

  assign q = sr[stages-1];

endmodule

// File: rtl/async_mem_wb_master_fe.sv
// Async SRAM-style bus to Wishbone B3 classic single-cycle master.
// Read data is returned on the tri-stated mem_d bus.
module async_mem_wb_master_fe
  import async_mem_bridge_pkg::*;
#(
  parameter int dw          = 32,
  parameter int aw          = 32,
  parameter int sync_stages = 2,
  parameter int timeout     = 16
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_n_i,
  inout  wire  [dw-1:0] mem_d,
  input  logic [aw-1:0] mem_a,
  input  logic          mem_oe_n,
  input  logic [3:0]    mem_bls_n,
  input  logic          mem_we_n,
  input  logic          mem_cs_n,
  output logic [aw-1:0] wb_adr_o,
  output logic [dw-1:0] wb_dat_o,
  input  logic [dw-1:0] wb_dat_i,
  output logic [3:0]    wb_sel_o,
  output logic          wb_we_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  input  logic          wb_ack_i,
  input  logic          wb_err_i,
  output logic          err_o
);

  localparam int tw = $clog2(timeout);
  localparam logic [tw-1:0] tmax = tw'(timeout - 1);

  state_t        state;
  logic [2:0]    strb_s;
  logic          cs_s;
  logic          we_s;
  logic          oe_s;
  logic          we_q;
  logic          oe_q;
  logic          rd_arm;
  logic [aw-1:0] a_q1;
  logic [aw-1:0] a_q2;
  logic [3:0]    bls_q1;
  logic [3:0]    bls_q2;
  logic [aw-1:0] last_rd;
  logic [tw-1:0] cnt;
  logic [dw-1:0] rd_q;
  logic          stable;
  logic          oe_fell;
  logic          wr_det;
  logic          rd_det;
  logic          drive;

  async_mem_sync #(
    .width (3),
    .stages(sync_stages)
  ) u_sync (
    .clk  (wb_clk_i),
    .rst_n(wb_rst_n_i),
    .d    ({mem_cs_n, mem_we_n, mem_oe_n}),
    .q    (strb_s)
  );

  assign cs_s = strb_s[2];
  assign we_s = strb_s[1];
  assign oe_s = strb_s[0];

  assign stable  = (a_q1 == a_q2);
  assign oe_fell = oe_q & ~oe_s;
  assign wr_det  = we_q & ~we_s & ~cs_s;
  assign rd_det  = ~cs_s & ~oe_s & we_s & stable
                 & (oe_fell | rd_arm | (a_q2 != last_rd));

  // rd_arm remembers an oe fall seen before the address settled
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      a_q1    <= '0;
      a_q2    <= '0;
      bls_q1  <= '1;
      bls_q2  <= '1;
      we_q    <= 1'b1;
      oe_q    <= 1'b1;
      rd_arm  <= 1'b0;
      last_rd <= '0;
    end else begin
      a_q1   <= mem_a;
      a_q2   <= a_q1;
      bls_q1 <= mem_bls_n;
      bls_q2 <= bls_q1;
      we_q   <= we_s;
      oe_q   <= oe_s;
      rd_arm <= ~rd_det & ~oe_s & (rd_arm | oe_fell);
      if (rd_det) begin
        last_rd <= a_q2;
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state    <= IDLE;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      wb_sel_o <= '0;
      wb_we_o  <= 1'b0;
      wb_cyc_o <= 1'b0;
      cnt      <= '0;
      rd_q     <= '0;
      err_o    <= 1'b0;
    end else begin
      if (cnt != tmax) begin
        cnt <= cnt + 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (wr_det) begin
            state    <= WR;
            wb_adr_o <= a_q2;
            wb_dat_o <= mem_d;
            wb_sel_o <= ~bls_q2;
            wb_we_o  <= 1'b1;
            wb_cyc_o <= 1'b1;
            cnt      <= '0;
          end else if (rd_det) begin
            state    <= RD;
            wb_adr_o <= a_q2;
            wb_sel_o <= ~bls_q2;
            wb_we_o  <= 1'b0;
            wb_cyc_o <= 1'b1;
            cnt      <= '0;
          end
        end
        WR, RD: begin
          if (wr_det | rd_det) begin
            err_o <= 1'b1;
          end
          if (wb_err_i | (cnt == tmax)) begin
            state    <= IDLE;
            wb_cyc_o <= 1'b0;
            wb_we_o  <= 1'b0;
            err_o    <= 1'b1;
            if (state == RD) begin
              rd_q <= ERR_DATA[dw-1:0];
            end
          end else if (wb_ack_i) begin
            state    <= IDLE;
            wb_cyc_o <= 1'b0;
            wb_we_o  <= 1'b0;
            if (state == RD) begin
              rd_q <= wb_dat_i;
            end
          end
        end
        default: begin
          state    <= IDLE;
          wb_cyc_o <= 1'b0;
          wb_we_o  <= 1'b0;
        end
      endcase
    end
  end

  assign wb_stb_o = wb_cyc_o;

  assign drive = ~mem_cs_n & ~mem_oe_n & mem_we_n;
  assign mem_d = drive ? rd_q : {dw{1'bz}};

endmodule
